// File: rtl/mult_pkg.sv
// Shared types and constants for the mult32x32 operand feeder.
package mult_pkg;

    localparam int unsigned OP_W          = 32;
    localparam int unsigned PROD_W        = 64;
    localparam int unsigned START_TIMEOUT = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_HI,
        WAIT_LO,
        DONE
    } feed_state_t;

    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } operand_t;

endpackage

// File: rtl/operand_fifo.sv
// Synchronous operand FIFO with wrap-around pointers; push/pop are ignored when full/empty.
module operand_fifo
    import mult_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  operand_t               din,
    input  logic                   pop,
    output operand_t               dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    operand_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage carries no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mult32x32_feeder.sv
// Issues queued operand pairs to a non-pipelined mult32x32 one at a time and
// captures each product into a valid/ready output holding register.
module mult32x32_feeder
    import mult_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OP_W-1:0]        in_a,
    input  logic [OP_W-1:0]        in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PROD_W-1:0]      out_product,
    output logic                   mul_start,
    output logic [OP_W-1:0]        mul_a,
    output logic [OP_W-1:0]        mul_b,
    input  logic                   mul_busy,
    input  logic [PROD_W-1:0]      mul_product,
    output logic [$clog2(DEPTH):0] pending
);

    localparam int unsigned TO_W = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

    feed_state_t     state;
    logic [TO_W-1:0] wait_cnt;
    operand_t        fifo_head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_push;
    logic            fifo_pop;

    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && !fifo_full;
    assign fifo_pop  = (state == START);

    operand_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   ('{a: in_a, b: in_b}),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (pending)
    );

    // Operands are latched on entry to START so mul_start and mul_a/mul_b appear together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            mul_start   <= 1'b0;
            mul_a       <= '0;
            mul_b       <= '0;
            out_valid   <= 1'b0;
            out_product <= '0;
        end else begin
            mul_start <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state     <= START;
                        mul_start <= 1'b1;
                        mul_a     <= fifo_head.a;
                        mul_b     <= fifo_head.b;
                    end
                end
                START: begin
                    state    <= WAIT_HI;
                    wait_cnt <= '0;
                end
                WAIT_HI: begin
                    // A multiplier that never raises busy is treated as already finished.
                    if (mul_busy || wait_cnt == TO_W'(START_TIMEOUT - 1)) begin
                        state <= WAIT_LO;
                    end else begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
                end
                WAIT_LO: begin
                    if (!mul_busy) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!out_valid || out_ready) begin
                        out_product <= mul_product;
                        out_valid   <= 1'b1;
                        if (!fifo_empty) begin
                            state     <= START;
                            mul_start <= 1'b1;
                            mul_a     <= fifo_head.a;
                            mul_b     <= fifo_head.b;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult32x32_feeder.sv
// Bench for mult32x32_feeder: behavioural multiplier with random latency, product scoreboard
// and occupancy model, plus directed scenario tasks.
module tb_mult32x32_feeder;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_a = '0;
    logic [31:0]   in_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [63:0]   out_product;
    logic          mul_start;
    logic [31:0]   mul_a;
    logic [31:0]   mul_b;
    logic          mul_busy;
    logic [63:0]   mul_product;
    logic [PW-1:0] pending;

    int errors = 0;
    int checks = 0;

    mult32x32_feeder #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .mul_start   (mul_start),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_busy    (mul_busy),
        .mul_product (mul_product),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    // Behavioural multiplier honouring the busy/product contract, latency lat_lo..lat_hi (0 = no busy).
    int          lat_lo = 1;
    int          lat_hi = 3;
    int          m_phase = 0;
    int          m_dly = 0;
    int          m_cnt = 0;
    int          m_lat;
    logic [31:0] m_a, m_b;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mul_busy    <= 1'b0;
            mul_product <= '0;
            m_phase     <= 0;
            m_dly       <= 0;
            m_cnt       <= 0;
            m_a         <= '0;
            m_b         <= '0;
        end else begin
            case (m_phase)
                0: if (mul_start && !mul_busy) begin
                    m_lat = $urandom_range(lat_hi, lat_lo);
                    m_a <= mul_a;
                    m_b <= mul_b;
                    if (m_lat == 0) begin
                        mul_product <= {32'h0, mul_a} * {32'h0, mul_b};
                    end else begin
                        mul_product <= {$urandom, $urandom};
                        m_dly   <= $urandom_range(1, 0);
                        m_cnt   <= m_lat;
                        m_phase <= 1;
                    end
                end
                1: if (m_dly == 0) begin
                    mul_busy <= 1'b1;
                    m_phase  <= 2;
                end else begin
                    m_dly <= m_dly - 1;
                end
                default: if (m_cnt <= 1) begin
                    mul_busy    <= 1'b0;
                    mul_product <= {32'h0, m_a} * {32'h0, m_b};
                    m_phase     <= 0;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            endcase
        end
    end

    // Reference model: expected products in issue order and FIFO occupancy.
    logic [63:0] exp_q[$];
    int          pend_model = 0;
    logic        start_prev = 1'b0;
    logic        mon_en = 1'b0;
    int          n_out = 0;

    always @(negedge clk) begin
        if (mon_en && reset) begin
            automatic logic acc = in_valid && (pend_model < int'(DEPTH));
            checks++;
            if (pending !== PW'(pend_model)) begin
                errors++;
                $display("FAIL pending: got %0d want %0d", pending, pend_model);
            end
            checks++;
            if (in_ready !== (pend_model < int'(DEPTH))) begin
                errors++;
                $display("FAIL in_ready: got %b want %b", in_ready, pend_model < int'(DEPTH));
            end
            if (mul_start) begin
                checks++;
                if (start_prev || m_phase != 0 || mul_busy) begin
                    errors++;
                    $display("FAIL start_pulse: got start with prev=%b busy=%b phase=%0d want lone pulse on idle multiplier",
                             start_prev, mul_busy, m_phase);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                n_out++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_extra: got %h want no result", out_product);
                end else begin
                    automatic logic [63:0] e = exp_q.pop_front();
                    if (out_product !== e) begin
                        errors++;
                        $display("FAIL out_product: got %h want %h", out_product, e);
                    end
                end
            end
            if (acc) begin
                exp_q.push_back({32'h0, in_a} * {32'h0, in_b});
            end
            pend_model = pend_model + (acc ? 1 : 0) - (mul_start ? 1 : 0);
            start_prev = mul_start;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_op(input logic [31:0] a, input logic [31:0] b);
        automatic logic acc = 1'b0;
        automatic int   guard = 0;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready;
            tick();
            guard++;
        end while (!acc && guard < 300);
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: got in_ready=0 for %0d cycles want acceptance", guard);
        end
    endtask

    task automatic wait_drain();
        automatic int guard = 0;
        while ((exp_q.size() != 0 || pending != 0 || out_valid || mul_busy) && guard < 2000) begin
            tick();
            guard++;
        end
        if (guard >= 2000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d results outstanding want 0", exp_q.size());
        end
        repeat (8) tick();
    endtask

    task automatic check_reset_values(input string tag);
        checks += 7;
        if (pending !== '0)        begin errors++; $display("FAIL %s_pending: got %0d want 0", tag, pending); end
        if (in_ready !== 1'b1)     begin errors++; $display("FAIL %s_in_ready: got %b want 1", tag, in_ready); end
        if (out_valid !== 1'b0)    begin errors++; $display("FAIL %s_out_valid: got %b want 0", tag, out_valid); end
        if (out_product !== '0)    begin errors++; $display("FAIL %s_out_product: got %h want 0", tag, out_product); end
        if (mul_start !== 1'b0)    begin errors++; $display("FAIL %s_mul_start: got %b want 0", tag, mul_start); end
        if (mul_a !== '0)          begin errors++; $display("FAIL %s_mul_a: got %h want 0", tag, mul_a); end
        if (mul_b !== '0)          begin errors++; $display("FAIL %s_mul_b: got %h want 0", tag, mul_b); end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        check_reset_values("reset");
        #2 reset = 1'b1;
        tick();
        mon_en = 1'b1;
    endtask

    task automatic test_single();
        automatic int          starts = 0;
        automatic int          first_start = -1;
        automatic int          vcycles = 0;
        automatic logic [63:0] got = '0;
        out_ready = 1'b1;
        lat_lo = 1; lat_hi = 3;
        push_op(32'd2, 32'd3);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (mul_start) begin
                starts++;
                if (first_start < 0) first_start = k;
                checks++;
                if (mul_a !== 32'd2 || mul_b !== 32'd3) begin
                    errors++;
                    $display("FAIL single_operands: got %0d,%0d want 2,3", mul_a, mul_b);
                end
            end
            if (out_valid) begin
                vcycles++;
                got = out_product;
            end
        end
        tick();
        checks += 4;
        if (first_start != 1) begin errors++; $display("FAIL single_issue_latency: got %0d want 1", first_start); end
        if (starts != 1)      begin errors++; $display("FAIL single_starts: got %0d want 1", starts); end
        if (vcycles != 1)     begin errors++; $display("FAIL single_valid_cycles: got %0d want 1", vcycles); end
        if (got !== 64'd6)    begin errors++; $display("FAIL single_product: got %0d want 6", got); end
    endtask

    task automatic test_fill();
        automatic logic [63:0] want [6] = '{64'd2, 64'd6, 64'd12, 64'd20, 64'd30, 64'd42};
        automatic int idx = 0;
        automatic int guard = 0;
        out_ready = 1'b0;
        lat_lo = 1; lat_hi = 2;
        for (int i = 1; i <= 6; i++) push_op(32'(i), 32'(i + 1));
        repeat (30) tick();
        checks += 4;
        if (in_ready !== 1'b0)              begin errors++; $display("FAIL fill_in_ready: got %b want 0", in_ready); end
        if (pending !== PW'(DEPTH))          begin errors++; $display("FAIL fill_pending: got %0d want %0d", pending, DEPTH); end
        if (out_valid !== 1'b1)             begin errors++; $display("FAIL fill_out_valid: got %b want 1", out_valid); end
        if (out_product !== 64'd2)          begin errors++; $display("FAIL fill_held: got %0d want 2", out_product); end
        // Offer an operand while full: the occupancy model rejects it.
        in_a = 32'd99; in_b = 32'd99; in_valid = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        while (idx < 6 && guard < 400) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                checks++;
                if (out_product !== want[idx]) begin
                    errors++;
                    $display("FAIL fill_order[%0d]: got %0d want %0d", idx, out_product, want[idx]);
                end
                idx++;
            end
            guard++;
        end
        tick();
        if (idx < 6) begin
            checks++; errors++;
            $display("FAIL fill_count: got %0d results want 6", idx);
        end
        wait_drain();
    endtask

    task automatic test_backpressure();
        automatic int guard = 0;
        automatic int got_n = 0;
        automatic int extra = 0;
        automatic logic [63:0] got [2];
        out_ready = 1'b0;
        lat_lo = 0; lat_hi = 3;
        push_op(32'd1, 32'd2);
        push_op(32'd2, 32'd3);
        while (!out_valid && guard < 100) begin tick(); guard++; end
        repeat (15) tick();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_product !== 64'd2) begin
                errors++;
                $display("FAIL bp_hold: got v=%b p=%0d want v=1 p=2", out_valid, out_product);
            end
        end
        tick();
        out_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) begin
                if (got_n < 2) got[got_n] = out_product;
                else extra++;
                got_n++;
            end
        end
        tick();
        checks += 3;
        if (got_n < 2 || got[0] !== 64'd2) begin errors++; $display("FAIL bp_first: got %0d want 2", got[0]); end
        if (got_n < 2 || got[1] !== 64'd6) begin errors++; $display("FAIL bp_second: got %0d want 6", got[1]); end
        if (extra != 0)                    begin errors++; $display("FAIL bp_dup: got %0d extra want 0", extra); end
        wait_drain();
    endtask

    task automatic test_max();
        automatic int guard = 0;
        out_ready = 1'b1;
        push_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do begin @(negedge clk); guard++; end while (!out_valid && guard < 100);
        checks++;
        if (out_product !== 64'hFFFF_FFFE_0000_0001) begin
            errors++;
            $display("FAIL max_product: got %h want fffffffe00000001", out_product);
        end
        tick();
        wait_drain();
    endtask

    task automatic test_random();
        automatic bit done = 1'b0;
        automatic int base = n_out;
        lat_lo = 0; lat_hi = 5;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    repeat ($urandom_range(2, 0)) tick();
                    push_op($urandom, $urandom);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(3, 0) != 0);
                    tick();
                end
            end
        join
        out_ready = 1'b1;
        wait_drain();
        checks++;
        if (n_out - base != 150) begin
            errors++;
            $display("FAIL random_count: got %0d results want 150", n_out - base);
        end
    endtask

    task automatic test_reset_midop();
        automatic int guard = 0;
        automatic int starts = 0;
        out_ready = 1'b0;
        lat_lo = 8; lat_hi = 8;
        for (int i = 0; i < 4; i++) push_op(32'(i + 5), 32'(i + 7));
        while (!mul_busy && guard < 50) begin tick(); guard++; end
        repeat (2) tick();
        mon_en = 1'b0;
        #2 reset = 1'b0;
        #1 check_reset_values("midop");
        exp_q.delete();
        pend_model = 0;
        start_prev = 1'b0;
        tick();
        #3 reset = 1'b1;
        tick();
        mon_en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mul_start) starts++;
        end
        tick();
        checks++;
        if (starts != 0) begin errors++; $display("FAIL midop_restart: got %0d starts want 0", starts); end
        lat_lo = 1; lat_hi = 3;
        out_ready = 1'b1;
        push_op(32'd7, 32'd6);
        wait_drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_backpressure();
        test_max();
        test_random();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
